c5_normalizer: RTL and testbench

- Sequential inverse of the c5 left shifter: given a 32-bit value, finds the left-shift amount that normalizes it and produces the normalized value.
- Unsigned mode counts leading zeros. Signed mode counts redundant sign bits.
- Feeding O_value's source and O_amount into the c5 shifter with SHIFT_LEFT_UNSIGNED reproduces O_value.
- Sits beside the shifter in the c5 datapath. It is multi-cycle, using a 5-step binary search, behind a valid/ready handshake.

---
 rtl/c5_pkg.sv | 20 ++
 rtl/c5_norm_step.sv | 28 ++
 rtl/c5_normalizer.sv | 117 +++++++++++
 tb/tb_c5_normalizer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/c5_pkg.sv
// Shared c5 datapath definitions: normalizer modes, FSM state encoding and step sizing.
package c5;

    localparam logic NORM_UNSIGNED = 1'b0;
    localparam logic NORM_SIGNED   = 1'b1;

    typedef enum logic [1:0] {
        NORM_IDLE = 2'd0,
        NORM_BUSY = 2'd1,
        NORM_DONE = 2'd2
    } norm_state_e;

    localparam int unsigned NORM_STEPS = 5;

    // Binary-search step size for step index 0..4: 16, 8, 4, 2, 1.
    function automatic logic [4:0] norm_step_size(input logic [2:0] idx);
        return 5'(5'd16 >> idx);
    endfunction

endpackage

// File: rtl/c5_norm_step.sv
// One binary-search normalization step: tests the top bits and shifts left by step_i on a hit.
module c5_norm_step
    import c5::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 5
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic [AMT_W-1:0] step_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] value_o,
    output logic             hit_o
);

    logic [AMT_W:0]   test_len;
    logic [WIDTH-1:0] top_mask;
    logic [WIDTH-1:0] cmp;

    always_comb begin
        // Signed mode must keep one copy of the sign bit, so it inspects s+1 bits.
        test_len = {1'b0, step_i} + ((mode_i == NORM_SIGNED) ? (AMT_W+1)'(1) : (AMT_W+1)'(0));
        top_mask = ~({WIDTH{1'b1}} >> test_len);
        cmp      = (mode_i == NORM_SIGNED) ? (value_i ^ {WIDTH{value_i[WIDTH-1]}}) : value_i;
        hit_o    = ((cmp & top_mask) == '0);
        value_o  = hit_o ? (value_i << step_i) : value_i;
    end

endmodule

// File: rtl/c5_normalizer.sv
// Multi-cycle normalizer: 5-step binary search for the left-shift amount behind valid/ready.
module c5_normalizer
    import c5::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 5
) (
    input  logic             I_clk,
    input  logic             I_reset,
    input  logic             I_valid,
    output logic             O_ready,
    input  logic [WIDTH-1:0] I_value,
    input  logic             I_norm_func,
    output logic             O_valid,
    input  logic             I_ready,
    output logic [WIDTH-1:0] O_value,
    output logic [AMT_W-1:0] O_amount,
    output logic             O_zero
);

    norm_state_e      state_q;
    logic [WIDTH-1:0] work_q;
    logic             mode_q;
    logic [AMT_W-1:0] amount_q;
    logic [2:0]       step_q;
    logic             op_zero_q;
    logic             ready_q;
    logic             valid_q;
    logic [WIDTH-1:0] value_q;
    logic [AMT_W-1:0] out_amount_q;
    logic             zero_q;

    logic [AMT_W-1:0] step_size;
    logic [WIDTH-1:0] step_value;
    logic             step_hit;
    logic [WIDTH-1:0] work_d;
    logic [AMT_W-1:0] amount_d;

    always_comb begin
        step_size = norm_step_size(step_q);
        work_d    = step_hit ? step_value : work_q;
        amount_d  = step_hit ? (amount_q + step_size) : amount_q;
    end

    c5_norm_step #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_step (
        .value_i (work_q),
        .step_i  (step_size),
        .mode_i  (mode_q),
        .value_o (step_value),
        .hit_o   (step_hit)
    );

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_q      <= NORM_IDLE;
            work_q       <= '0;
            mode_q       <= NORM_UNSIGNED;
            amount_q     <= '0;
            step_q       <= '0;
            op_zero_q    <= 1'b0;
            ready_q      <= 1'b1;
            valid_q      <= 1'b0;
            value_q      <= '0;
            out_amount_q <= '0;
            zero_q       <= 1'b0;
        end else begin
            unique case (state_q)
                NORM_IDLE: begin
                    if (I_valid && ready_q) begin
                        work_q    <= I_value;
                        mode_q    <= I_norm_func;
                        amount_q  <= '0;
                        step_q    <= '0;
                        op_zero_q <= (I_value == '0) || (I_value == '1);
                        ready_q   <= 1'b0;
                        state_q   <= NORM_BUSY;
                    end
                end
                NORM_BUSY: begin
                    work_q   <= work_d;
                    amount_q <= amount_d;
                    step_q   <= step_q + 3'd1;
                    if (step_q == 3'(NORM_STEPS - 1)) begin
                        value_q      <= work_d;
                        out_amount_q <= amount_d;
                        // Signed all-sign operands still leave a nonzero 0x80000000 behind.
                        zero_q       <= (mode_q == NORM_SIGNED) ? op_zero_q : (work_d == '0);
                        valid_q      <= 1'b1;
                        state_q      <= NORM_DONE;
                    end
                end
                NORM_DONE: begin
                    if (I_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= NORM_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= NORM_IDLE;
                end
            endcase
        end
    end

    assign O_ready  = ready_q;
    assign O_valid  = valid_q;
    assign O_value  = value_q;
    assign O_amount = out_amount_q;
    assign O_zero   = zero_q;

endmodule

// File: tb/tb_c5_normalizer.sv
// Directed-vector and random self-checking bench for c5_normalizer.
module tb_c5_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_value;
    logic        in_func;
    logic        out_valid;
    logic        in_ready;
    logic [31:0] out_value;
    logic [4:0]  out_amount;
    logic        out_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    c5_normalizer #(
        .WIDTH (32),
        .AMT_W (5)
    ) dut (
        .I_clk       (clk),
        .I_reset     (rst),
        .I_valid     (in_valid),
        .O_ready     (out_ready),
        .I_value     (in_value),
        .I_norm_func (in_func),
        .O_valid     (out_valid),
        .I_ready     (in_ready),
        .O_value     (out_value),
        .O_amount    (out_amount),
        .O_zero      (out_zero)
    );

    typedef struct {
        logic [31:0] value;
        logic        func;
        logic [31:0] exp_value;
        logic [4:0]  exp_amount;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model(input logic [31:0] v, input logic f, output logic [4:0] a,
                         output logic [31:0] r, output logic z);
        int n;
        if (!f) begin
            n = 0;
            while (n < 32 && !v[31-n]) n++;
            a = (n > 31) ? 5'd31 : 5'(n);
            z = (v == 32'h0);
        end else begin
            n = 1;
            while (n < 32 && v[31-n] == v[31]) n++;
            a = 5'(n - 1);
            z = (v == 32'h0) || (v == 32'hFFFF_FFFF);
        end
        r = v << a;
    endtask

    // Accept edge is the tick below; operand inputs are scrambled afterwards.
    task automatic start_op(input logic [31:0] v, input logic f);
        int n = 0;
        while (!out_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_before_accept", 32'(out_ready), 32'd1);
        in_valid = 1'b1;
        in_value = v;
        in_func  = f;
        tick();
        in_valid = 1'b0;
        in_value = ~v;
        in_func  = ~f;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    int          lat;
    logic [4:0]  m_amt;
    logic [31:0] m_val;
    logic        m_zero;
    logic [31:0] hold_value;
    logic [4:0]  hold_amount;
    logic        hold_zero;
    logic [31:0] rv;
    logic        rf;

    initial begin
        vecs[0]  = '{32'h0000_0010, 1'b0, 32'h8000_0000, 5'd27, 1'b0};
        vecs[1]  = '{32'hF800_0000, 1'b1, 32'h8000_0000, 5'd4,  1'b0};
        vecs[2]  = '{32'h0000_0001, 1'b1, 32'h4000_0000, 5'd30, 1'b0};
        vecs[3]  = '{32'h0000_0000, 1'b0, 32'h0000_0000, 5'd31, 1'b1};
        vecs[4]  = '{32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 5'd31, 1'b1};
        vecs[5]  = '{32'h8000_0000, 1'b0, 32'h8000_0000, 5'd0,  1'b0};
        vecs[6]  = '{32'h0000_0000, 1'b1, 32'h0000_0000, 5'd31, 1'b1};
        vecs[7]  = '{32'h8000_0000, 1'b1, 32'h8000_0000, 5'd0,  1'b0};
        vecs[8]  = '{32'h4000_0000, 1'b1, 32'h4000_0000, 5'd0,  1'b0};
        vecs[9]  = '{32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0};
        vecs[10] = '{32'h0001_2345, 1'b0, 32'h91A2_8000, 5'd15, 1'b0};
        vecs[11] = '{32'hFFFF_8000, 1'b1, 32'h8000_0000, 5'd16, 1'b0};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_value = 32'h0;
        in_func  = 1'b0;
        in_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("reset_ready",  32'(out_ready),  32'd1);
        check("reset_valid",  32'(out_valid),  32'd0);
        check("reset_value",  out_value,       32'h0);
        check("reset_amount", 32'(out_amount), 32'd0);
        check("reset_zero",   32'(out_zero),   32'd0);

        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].value, vecs[i].func);
            wait_done(lat);
            // Counting the accept edge as edge 1, O_valid rises on edge 6.
            check("latency", 32'(lat), 32'd5);
            check("vec_value",  out_value,       vecs[i].exp_value);
            check("vec_amount", 32'(out_amount), 32'(vecs[i].exp_amount));
            check("vec_zero",   32'(out_zero),   32'(vecs[i].exp_zero));
            check("vec_busy_ready", 32'(out_ready), 32'd0);
            tick();
            check("vec_release_valid", 32'(out_valid), 32'd0);
            check("vec_release_ready", 32'(out_ready), 32'd1);
        end

        // Backpressure: result held while a competing request is presented.
        in_ready = 1'b0;
        start_op(32'h0000_0300, 1'b0);
        wait_done(lat);
        check("bp_latency", 32'(lat), 32'd5);
        hold_value  = out_value;
        hold_amount = out_amount;
        hold_zero   = out_zero;
        check("bp_value",  hold_value,        32'hC000_0000);
        check("bp_amount", 32'(hold_amount),  32'd22);
        in_valid = 1'b1;
        in_value = 32'h0000_0001;
        in_func  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_hold_valid",  32'(out_valid),  32'd1);
            check("bp_hold_ready",  32'(out_ready),  32'd0);
            check("bp_hold_value",  out_value,       hold_value);
            check("bp_hold_amount", 32'(out_amount), 32'(hold_amount));
            check("bp_hold_zero",   32'(out_zero),   32'(hold_zero));
        end
        in_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(out_ready), 32'd1);
        in_valid = 1'b0;
        tick();
        check("bp_no_accept", 32'(out_ready), 32'd1);

        // Reset in BUSY after two steps aborts with no result.
        start_op(32'h0000_00FF, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready",  32'(out_ready),  32'd1);
        check("abort_valid",  32'(out_valid),  32'd0);
        check("abort_value",  out_value,       32'h0);
        check("abort_amount", 32'(out_amount), 32'd0);
        check("abort_zero",   32'(out_zero),   32'd0);
        for (int c = 0; c < 8; c++) begin
            tick();
            check("abort_no_result", 32'(out_valid), 32'd0);
        end
        start_op(32'h0000_00FF, 1'b0);
        wait_done(lat);
        check("after_abort_latency", 32'(lat), 32'd5);
        check("after_abort_value",  out_value,       32'hFF00_0000);
        check("after_abort_amount", 32'(out_amount), 32'd24);
        tick();

        for (int i = 0; i < 1000; i++) begin
            rf = i[0];
            rv = $urandom >> $urandom_range(0, 31);
            if (rf && ($urandom_range(0, 1) == 1)) rv = ~rv;
            model(rv, rf, m_amt, m_val, m_zero);
            start_op(rv, rf);
            wait_done(lat);
            check("rnd_valid",  32'(out_valid),  32'd1);
            check("rnd_amount", 32'(out_amount), 32'(m_amt));
            check("rnd_shift",  out_value,       rv << out_amount);
            check("rnd_value",  out_value,       m_val);
            check("rnd_zero",   32'(out_zero),   32'(m_zero));
            if (rf)
                check("rnd_signed_norm", 32'(out_zero || (out_value[31] != out_value[30])), 32'd1);
            else
                check("rnd_unsigned_norm", 32'(out_zero || out_value[31]), 32'd1);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
